// File: rtl/btn_sw_input.sv
// btn_sw_input: debounced board switches and buttons behind a small register bus.
//   clk, rst_n      - clock and asynchronous active-low reset
//   switches[23:0]  - raw switches (asynchronous to clk)
//   button[4:0]     - raw buttons (asynchronous to clk), 1 = pressed
//   addr[11:0]      - bus word offset; addr[11:2] decoded, addr[1:0] ignored
//   wen, wdata      - bus write strobe and data
//   rdata[31:0]     - combinational read data for addr
//   irq             - registered level interrupt, any enabled press event pending
// Map: 0x000 SW (RO), 0x004 BTN (RO), 0x008 EDGE (W1C), 0x00C IRQ_EN (RW).
module btn_sw_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] switches,
    input  logic [4:0]  button,
    input  logic [11:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NB = 5;
    localparam int unsigned NS = 24;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [9:0] A_SW     = 10'd0;
    localparam logic [9:0] A_BTN    = 10'd1;
    localparam logic [9:0] A_EDGE   = 10'd2;
    localparam logic [9:0] A_IRQ_EN = 10'd3;

    logic [NS-1:0] sw_meta, sw_sync, sw_prev, sw_stable, sw_stable_next;
    logic [CW-1:0] sw_cnt, sw_cnt_next, sw_base;

    logic [NB-1:0] btn_meta, btn_sync, btn_stable, btn_stable_next, btn_stable_d;
    logic [NB-1:0][CW-1:0] btn_cnt, btn_cnt_next;

    logic [NB-1:0] edge_flags, edge_next, edge_set, edge_clr;
    logic [NB-1:0] irq_en, irq_en_next;
    logic          wr_edge, wr_irq_en;

    // Ignored address/data bits are collected here so they are visibly unused.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:NB]};

    // Switch group debounce: a change in the synced vector restarts the count,
    // counting that change cycle as the first stable cycle.
    always_comb begin
        sw_stable_next = sw_stable;
        sw_cnt_next    = '0;
        sw_base        = '0;
        if (sw_sync != sw_stable) begin
            sw_base = (sw_sync != sw_prev) ? '0 : sw_cnt;
            if (sw_base == LAST) begin
                sw_stable_next = sw_sync;
            end else begin
                sw_cnt_next = sw_base + CW'(1);
            end
        end
    end

    // Per-bit button debounce.
    always_comb begin
        btn_stable_next = btn_stable;
        btn_cnt_next    = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (btn_sync[i] != btn_stable[i]) begin
                if (btn_cnt[i] == LAST) begin
                    btn_stable_next[i] = btn_sync[i];
                end else begin
                    btn_cnt_next[i] = btn_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press events and interrupt enable; a new press beats a same-cycle clear.
    always_comb begin
        wr_edge     = wen && (addr[11:2] == A_EDGE);
        wr_irq_en   = wen && (addr[11:2] == A_IRQ_EN);
        edge_set    = btn_stable & ~btn_stable_d;
        edge_clr    = wr_edge ? wdata[NB-1:0] : '0;
        edge_next   = (edge_flags & ~edge_clr) | edge_set;
        irq_en_next = wr_irq_en ? wdata[NB-1:0] : irq_en;
    end

    // Read mux over current register state.
    always_comb begin
        rdata = '0;
        case (addr[11:2])
            A_SW:     rdata = {8'b0, sw_stable};
            A_BTN:    rdata = {27'b0, btn_stable};
            A_EDGE:   rdata = {27'b0, edge_flags};
            A_IRQ_EN: rdata = {27'b0, irq_en};
            default:  rdata = '0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta      <= '0;
            sw_sync      <= '0;
            sw_prev      <= '0;
            sw_stable    <= '0;
            sw_cnt       <= '0;
            btn_meta     <= '0;
            btn_sync     <= '0;
            btn_stable   <= '0;
            btn_stable_d <= '0;
            btn_cnt      <= '0;
            edge_flags   <= '0;
            irq_en       <= '0;
            irq          <= 1'b0;
        end else begin
            sw_meta      <= switches;
            sw_sync      <= sw_meta;
            sw_prev      <= sw_sync;
            sw_stable    <= sw_stable_next;
            sw_cnt       <= sw_cnt_next;
            btn_meta     <= button;
            btn_sync     <= btn_meta;
            btn_stable   <= btn_stable_next;
            btn_stable_d <= btn_stable;
            btn_cnt      <= btn_cnt_next;
            edge_flags   <= edge_next;
            irq_en       <= irq_en_next;
            irq          <= |(edge_next & irq_en_next);
        end
    end

endmodule

// File: doc/btn_sw_input.md
BTN_SW_INPUT -- requirements
Module: btn_sw_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required before a synchronized input is accepted; legal range >= 1.
REQ-002 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1: asynchronous, active-low reset.
REQ-004 Port switches  input  24: raw board switches, asynchronous to clk.
REQ-005 Port button  input  5: raw board buttons, asynchronous to clk, 1 = pressed.
REQ-006 Port addr  input  12: bus word offset from the bridge; addr[11:2] decoded, addr[1:0] ignored.
REQ-007 Port wen  input  1: bus write strobe, one write per cycle when high.
REQ-008 Port wdata  input  32: bus write data.
REQ-009 Port rdata  output  32: bus read data, combinational from addr and current register state.
REQ-010 Port irq  output  1: registered level interrupt, high while any enabled button-press event is pending.

Function
REQ-011 Register map: 0x000 SW (RO) = {8'b0, sw_stable}; 0x004 BTN (RO) = {27'b0, btn_stable}; 0x008 EDGE (R/W1C) = {27'b0, edge}; 0x00C IRQ_EN (R/W) = {27'b0, irq_en}.
REQ-012 Unmapped offsets read 32'h0; writes to them, to SW, or to BTN have no effect.
REQ-013 Every switch and button bit passes through a 2-flop synchronizer before any other logic.
REQ-014 Buttons: one counter per bit, width $clog2(DEBOUNCE_CYCLES+1); counter clears whenever synced bit equals btn_stable bit, otherwise increments.
REQ-015 Button bit: when its counter reaches DEBOUNCE_CYCLES-1 and synced still differs, btn_stable takes the synced value on that edge and the counter clears.
REQ-016 Switches: one shared group counter; counter clears whenever the synced vector equals sw_stable or changed since the previous cycle; otherwise increments.
REQ-017 Switch group: when the group counter reaches DEBOUNCE_CYCLES-1 with the vector unchanged, sw_stable loads the full synced vector and the counter clears.
REQ-018 Latency: an input held constant from edge 0 is visible in SW/BTN after edge DEBOUNCE_CYCLES+2, not earlier.
REQ-019 Glitch shorter than DEBOUNCE_CYCLES synced cycles never changes stable state.
REQ-020 edge[i] sets on the edge after btn_stable[i] goes 0->1; release (1->0) sets nothing.
REQ-021 Write to EDGE clears each edge bit whose wdata bit is 1; bits with wdata 0 unchanged.
REQ-022 Same-cycle set and W1C clear of one edge bit: set wins, bit ends at 1.
REQ-023 Write to IRQ_EN loads irq_en <= wdata[4:0]; wdata[31:5] ignored.
REQ-024 irq is registered: irq <= |(edge_next & irq_en_next), i.e. irq reflects the post-edge state one cycle after the causing event or write.
REQ-025 Read of EDGE in the cycle of a W1C write returns the pre-write value.
REQ-026 Counters saturate-free by construction; no counter exceeds DEBOUNCE_CYCLES-1.

Reset
REQ-027 While rst_n low: synchronizer flops, sw_stable, btn_stable, all counters, edge, irq_en, irq all 0; rdata follows REQ-011 with these zeros.
REQ-028 Reset asserted mid-debounce discards the partial count; after rst_n rises, a held input needs the full DEBOUNCE_CYCLES+2 again.
REQ-029 Input already high at rst_n release: btn_stable rises after DEBOUNCE_CYCLES+2 edges and sets edge (counts as a press).

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Hold button=5'b00001 from edge 0 -> BTN reads 1 from edge 6, EDGE reads 1 from edge 7; irq stays 0 with irq_en=0.
REQ-031 Pulse button[2] high for 3 cycles -> BTN and EDGE remain 0 indefinitely.
REQ-032 switches=24'hA5A5A5, change to 24'h000001 at edge 3 of counting -> SW reads 0 until 4 stable cycles after the change, then 32'h00000001.
REQ-033 irq_en=5'h1F, press button[0] and [3] -> EDGE=5'h09, irq=1; write EDGE 32'h1 -> EDGE=5'h08, irq=1; write 32'h8 -> EDGE=0, irq=0 next edge.
REQ-034 W1C of bit 1 on the exact cycle edge[1] sets -> EDGE bit 1 reads 1 afterwards.
REQ-035 rst_n low during button[4] counter=2, release with button held -> BTN[4] rises exactly 6 edges after rst_n deassertion; reads of 0x010 return 0.
